// File: rtl/dsp_mac_pkg.sv
// Shared widths for the DSP multiply-add arbiter: operand, result and grant-counter sizes.
package dsp_mac_pkg;
  localparam int A_W   = 18;
  localparam int B_W   = 18;
  localparam int C_W   = 48;
  localparam int P_W   = 48;
  localparam int CNT_W = 16;

  typedef logic [A_W-1:0]   opa_t;
  typedef logic [B_W-1:0]   opb_t;
  typedef logic [C_W-1:0]   opc_t;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first set request at or above the pointer, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);
  always_comb begin
    int w_j;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = (int'(i_ptr) + k) % NREQ;
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = IDW'(w_j);
      end
    end
  end
endmodule

// File: rtl/dsp_mac_arbiter.sv
// Round-robin arbiter sharing one pipelined multiply-add macro among NREQ requesters.
// Optional per-requester grant counters are enabled by defining DSP_MAC_ARB_STATS_EN.
module dsp_mac_arbiter
  import dsp_mac_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DSP_LAT = 3
) (
  input  logic                          CLK_0,
  input  logic                          RST_0,
  input  logic [NREQ-1:0]               REQ_VALID,
  output logic [NREQ-1:0]               REQ_READY,
  input  logic [A_W*NREQ-1:0]           REQ_A,
  input  logic [B_W*NREQ-1:0]           REQ_B,
  input  logic [C_W*NREQ-1:0]           REQ_C,
  output logic [A_W-1:0]                DSP_A,
  output logic [B_W-1:0]                DSP_B,
  output logic [C_W-1:0]                DSP_C,
  input  logic [P_W-1:0]                DSP_P,
  output logic                          RSP_VALID,
  output logic [$clog2(NREQ)-1:0]       RSP_ID,
  output logic [P_W-1:0]                RSP_P
`ifdef DSP_MAC_ARB_STATS_EN
  ,
  output logic [CNT_W*NREQ-1:0]         GRANT_CNT
`endif
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0] w_req;
  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_idx;
  logic            w_any;

  logic [IDW-1:0]     r_ptr;
  opa_t               r_a_p0;
  opb_t               r_b_p0;
  opc_t               r_c_p0;
  logic               r_vld_p0;
  logic [IDW-1:0]     r_id_p0;
  logic [DSP_LAT-1:0] r_tag_vld;
  logic [IDW-1:0]     r_tag_id [DSP_LAT];

  // Reset masks requests so nothing is granted or sampled while RST_0 is high.
  assign w_req = REQ_VALID & {NREQ{~RST_0}};

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign REQ_READY = w_gnt;

  // Issue stage p0: operands captured only on a handshake, otherwise driven to zero.
  always_ff @(posedge CLK_0) begin
    if (w_any) begin
      r_a_p0 <= REQ_A[w_idx*A_W +: A_W];
      r_b_p0 <= REQ_B[w_idx*B_W +: B_W];
      r_c_p0 <= REQ_C[w_idx*C_W +: C_W];
    end else begin
      r_a_p0 <= '0;
      r_b_p0 <= '0;
      r_c_p0 <= '0;
    end
    r_id_p0     <= w_idx;
    r_tag_id[0] <= r_id_p0;
    for (int i = 1; i < DSP_LAT; i++) r_tag_id[i] <= r_tag_id[i-1];
  end

  always_ff @(posedge CLK_0) begin
    if (RST_0) begin
      r_ptr     <= '0;
      r_vld_p0  <= 1'b0;
      r_tag_vld <= '0;
    end else begin
      if (w_any) r_ptr <= (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + 1'b1;
      r_vld_p0     <= w_any;
      r_tag_vld[0] <= r_vld_p0;
      for (int i = 1; i < DSP_LAT; i++) r_tag_vld[i] <= r_tag_vld[i-1];
    end
  end

  assign DSP_A = r_a_p0;
  assign DSP_B = r_b_p0;
  assign DSP_C = r_c_p0;

  // Tag pipe is as deep as the macro, so the last stage lines up with DSP_P.
  assign RSP_VALID = r_tag_vld[DSP_LAT-1];
  assign RSP_ID    = r_tag_id[DSP_LAT-1];
  assign RSP_P     = DSP_P;

`ifdef DSP_MAC_ARB_STATS_EN
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  cnt_t r_cnt [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    always_ff @(posedge CLK_0) begin
      if (RST_0)         r_cnt[g] <= '0;
      else if (w_gnt[g]) r_cnt[g] <= sat_inc(r_cnt[g]);
    end
    assign GRANT_CNT[g*CNT_W +: CNT_W] = r_cnt[g];
  end
`endif
endmodule

// File: tb/tb_dsp_mac_arbiter.sv
// Directed bench for dsp_mac_arbiter with a behavioural 3-stage multiply-add macro.
module tb_dsp_mac_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 3;

  logic              CLK_0 = 1'b0;
  logic              RST_0;
  logic [NREQ-1:0]   REQ_VALID;
  logic [NREQ-1:0]   REQ_READY;
  logic [18*NREQ-1:0] REQ_A, REQ_B;
  logic [48*NREQ-1:0] REQ_C;
  logic [17:0]       DSP_A, DSP_B;
  logic [47:0]       DSP_C, DSP_P;
  logic              RSP_VALID;
  logic [1:0]        RSP_ID;
  logic [47:0]       RSP_P;
`ifdef DSP_MAC_ARB_STATS_EN
  logic [16*NREQ-1:0] GRANT_CNT;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 CLK_0 = ~CLK_0;

  dsp_mac_arbiter #(.NREQ(NREQ), .DSP_LAT(LAT)) dut (
    .CLK_0     (CLK_0),
    .RST_0     (RST_0),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_A     (REQ_A),
    .REQ_B     (REQ_B),
    .REQ_C     (REQ_C),
    .DSP_A     (DSP_A),
    .DSP_B     (DSP_B),
    .DSP_C     (DSP_C),
    .DSP_P     (DSP_P),
    .RSP_VALID (RSP_VALID),
    .RSP_ID    (RSP_ID),
    .RSP_P     (RSP_P)
`ifdef DSP_MAC_ARB_STATS_EN
    ,
    .GRANT_CNT (GRANT_CNT)
`endif
  );

  // Macro model: P = A*B + C, signed, three register stages after DSP_A/B/C.
  logic signed [47:0] m0, m1, m2;
  always @(posedge CLK_0) begin
    m0 <= $signed(DSP_A) * $signed(DSP_B) + $signed(DSP_C);
    m1 <= m0;
    m2 <= m1;
  end
  assign DSP_P = m2;

  task automatic tick();
    @(posedge CLK_0);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [17:0] a, input logic [17:0] b,
                         input logic [47:0] c);
    REQ_A[i*18 +: 18] = a;
    REQ_B[i*18 +: 18] = b;
    REQ_C[i*48 +: 48] = c;
  endtask

  initial begin
    RST_0 = 1'b1;
    REQ_VALID = '0;
    REQ_A = '0;
    REQ_B = '0;
    REQ_C = '0;

    // Reset: requests are ignored and outputs are quiet.
    REQ_VALID = 4'hF;
    tick();
    tick();
    chk("rst_ready", REQ_READY, 0);
    chk("rst_dsp_a", DSP_A, 0);
    chk("rst_dsp_c", DSP_C, 0);
    chk("rst_rsp_vld", RSP_VALID, 0);

    // Single op from req0 on the first cycle out of reset: 25*10+100 = 350.
    RST_0 = 1'b0;
    REQ_VALID = 4'b0001;
    set_ops(0, 18'd25, 18'd10, 48'd100);
    settle();
    chk("first_ready", REQ_READY, 4'b0001);
    tick();
    chk("issue_a", DSP_A, 25);
    chk("issue_b", DSP_B, 10);
    chk("issue_c", DSP_C, 100);
    chk("issue_rsp_vld", RSP_VALID, 0);
    REQ_VALID = '0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("single_rsp_vld", RSP_VALID, (c == LAT) ? 1 : 0);
      if (c == 1) chk("single_gap_a", DSP_A, 0);
      if (c == LAT) begin
        chk("single_rsp_id", RSP_ID, 0);
        chk("single_rsp_p", RSP_P, 350);
      end
    end

    // Pointer at 1: grant 1, then {1,3} valid gives 3 before 1.
    REQ_VALID = 4'b0010;
    settle();
    chk("rr_g1", REQ_READY, 4'b0010);
    tick();
    REQ_VALID = 4'b1010;
    settle();
    chk("rr_g3", REQ_READY, 4'b1000);
    tick();
    chk("rr_g1b", REQ_READY, 4'b0010);
    tick();
    REQ_VALID = '0;
    tick();
    chk("rr_rsp0_id", RSP_ID, 1);
    tick();
    chk("rr_rsp1_id", RSP_ID, 3);
    tick();
    chk("rr_rsp2_vld", RSP_VALID, 1);
    chk("rr_rsp2_id", RSP_ID, 1);
    tick();
    chk("rr_rsp_end", RSP_VALID, 0);

    // Idle gap between two req2 issues; second op is signed: -2*7+1 = -13.
    set_ops(2, 18'd3, 18'd4, 48'd5);
    REQ_VALID = 4'b0100;
    settle();
    chk("gap_ready0", REQ_READY, 4'b0100);
    tick();
    chk("gap_a0", DSP_A, 3);
    REQ_VALID = '0;
    tick();
    chk("gap_a_zero", DSP_A, 0);
    chk("gap_b_zero", DSP_B, 0);
    chk("gap_c_zero", DSP_C, 0);
    set_ops(2, 18'h3FFFE, 18'd7, 48'd1);
    REQ_VALID = 4'b0100;
    settle();
    chk("gap_ready1", REQ_READY, 4'b0100);
    tick();
    chk("gap_a1", DSP_A, 18'h3FFFE);
    REQ_VALID = '0;
    tick();
    chk("gap_rsp0_vld", RSP_VALID, 1);
    chk("gap_rsp0_p", RSP_P, 17);
    chk("gap_rsp0_id", RSP_ID, 2);
    tick();
    chk("gap_rsp_hole", RSP_VALID, 0);
    tick();
    chk("gap_rsp1_vld", RSP_VALID, 1);
    chk("gap_rsp1_p", RSP_P, 48'hFFFF_FFFF_FFF3);
    tick();
    chk("gap_rsp_end", RSP_VALID, 0);

    // Move pointer back to 0 via req3, then drain.
    REQ_VALID = 4'b1000;
    settle();
    chk("wrap_g3", REQ_READY, 4'b1000);
    tick();
    REQ_VALID = '0;
    repeat (4) tick();

    // All four valid for 8 cycles: grants 0,1,2,3,0,1,2,3 and in-order responses.
    for (int i = 0; i < NREQ; i++) set_ops(i, 18'(i + 1), 18'd100, 48'(i));
    for (int c = 0; c < 12; c++) begin
      REQ_VALID = (c < 8) ? 4'hF : 4'h0;
      settle();
      if (c < 8) chk("burst_ready", REQ_READY, 4'b0001 << (c % 4));
      tick();
      if (c >= LAT && c < 8 + LAT) begin
        chk("burst_rsp_vld", RSP_VALID, 1);
        chk("burst_rsp_id", RSP_ID, (c - LAT) % 4);
        chk("burst_rsp_p", RSP_P, 100 * ((c - LAT) % 4 + 1) + (c - LAT) % 4);
      end else begin
        chk("burst_rsp_idle", RSP_VALID, 0);
      end
    end

    // Reset one cycle after a req2 issue drops it; pointer returns to 0.
    set_ops(2, 18'd50, 18'd40, 48'd200);
    REQ_VALID = 4'b0100;
    settle();
    chk("rstmid_ready", REQ_READY, 4'b0100);
    tick();
    RST_0 = 1'b1;
    settle();
    chk("rstmid_ready_masked", REQ_READY, 0);
    tick();
    chk("rstmid_dsp_a", DSP_A, 0);
    chk("rstmid_rsp0", RSP_VALID, 0);
    RST_0 = 1'b0;
    REQ_VALID = 4'b1100;
    settle();
    chk("rstmid_ptr0", REQ_READY, 4'b0100);
    tick();
    chk("rstmid_a", DSP_A, 50);
    REQ_VALID = '0;
    tick();
    chk("rstmid_dropped", RSP_VALID, 0);
    tick();
    chk("rstmid_rsp_quiet", RSP_VALID, 0);
    tick();
    chk("rstmid_rsp_vld", RSP_VALID, 1);
    chk("rstmid_rsp_id", RSP_ID, 2);
    chk("rstmid_rsp_p", RSP_P, 2200);
    tick();
    chk("rstmid_rsp_end", RSP_VALID, 0);

`ifdef DSP_MAC_ARB_STATS_EN
    // 70000 grants to req0 saturate its counter; others stay at 0.
    RST_0 = 1'b1;
    tick();
    RST_0 = 1'b0;
    chk("cnt_rst", GRANT_CNT, 0);
    REQ_VALID = 4'b0001;
    repeat (70000) @(posedge CLK_0);
    #1;
    REQ_VALID = '0;
    tick();
    chk("cnt0_sat", GRANT_CNT[15:0], 16'hFFFF);
    chk("cnt_others", GRANT_CNT[63:16], 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
